wifi_rx_fft_controller: RTL and testbench
=========================================

Name: wifi_rx_fft_controller

Overview:
Receive-side counterpart of the TX IFFT controller in the WIFI PHY. It takes time-domain baseband samples after timing sync, strips the 16-sample cyclic prefix, and streams each 64-sample symbol body to the FFT core. It buffers the 64 FFT output bins and re-emits the 48 data subcarriers in standard order (-26..-1, +1..+26, nulls and pilots removed) to the demapper under a ready handshake.

Parameters:
SAMPLE_WIDTH, 12, bit width of each real/imag component on every data port
CP_LEN, 16, cyclic-prefix samples discarded per OFDM symbol
N_FFT, 64, FFT size; also the bin-buffer depth

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_re  in  SAMPLE_WIDTH  received sample, real part
rx_im  in  SAMPLE_WIDTH  received sample, imag part
valid_in  in  1  rx sample valid this cycle
sym_start  in  1  pulse coincident with the first CP sample of a data symbol, from sync
last_symbol  in  1  sampled with sym_start; marks the final symbol of the frame
fft_in_re  out  SAMPLE_WIDTH  sample to FFT, real part
fft_in_im  out  SAMPLE_WIDTH  sample to FFT, imag part
fft_in_valid  out  1  FFT input sample valid
fft_in_first  out  1  high with the first of the 64 FFT input samples
fft_abort  out  1  1-cycle pulse: discard the partial input block
fft_out_re  in  SAMPLE_WIDTH  FFT bin, real part, natural order 0..63
fft_out_im  in  SAMPLE_WIDTH  FFT bin, imag part
fft_out_valid  in  1  FFT bin valid
demap_ready  in  1  demapper can accept a subcarrier
sym_re  out  SAMPLE_WIDTH  data subcarrier, real part
sym_im  out  SAMPLE_WIDTH  data subcarrier, imag part
valid_out  out  1  subcarrier valid
sub_idx  out  6  data subcarrier index, 0..47
last_out  out  1  high with sub_idx 47 of the final symbol
overflow  out  1  sticky: an FFT bin arrived while the buffer was busy; cleared only by reset

Behaviour:
- Reset value of every output is 0. Async reset returns both FSMs to idle and clears all counters and the sticky flags.
- Input FSM states are I_IDLE, I_CP and I_LOAD. Counters advance only on valid_in=1; valid_in=0 stalls them.
- I_IDLE: on sym_start with valid_in, count the current sample as CP sample 0, latch last_symbol into in_last, and go to I_CP.
- I_CP: drop samples until CP_LEN are counted, then go to I_LOAD.
- I_LOAD: forward each sample combinationally as fft_in_* with fft_in_valid (no added latency). fft_in_first is high on sample 0.
- After sample 63 of I_LOAD: go to I_IDLE if in_last=1, else straight to I_CP (back-to-back symbols). in_last is pushed to a 2-entry last-flag FIFO read by the output side.
- sym_start while in I_CP or I_LOAD resyncs: pulse fft_abort if in I_LOAD, restart CP count at 0, relatch last_symbol.
- Output FSM states are O_WRITE and O_READ. O_WRITE writes incoming bins into a 64-entry buffer at address 0..63. After bin 63 it pops the last flag and goes to O_READ.
- O_READ emits bins 38..63 then 1..26, skipping 43, 57, 7 and 21 (pilots). Exactly 48 outputs. The buffer read is registered: valid_out follows the read by 1 cycle.
- An output transfers when valid_out & demap_ready. If demap_ready=0, sym_*, sub_idx and valid_out hold.
- After transfer of sub_idx 47, return to O_WRITE; last_out rides on that beat when the popped flag=1.
- fft_out_valid during O_READ: bin dropped, overflow set, FSM unaffected.
- Arithmetic: data passes unmodified; no scaling or saturation.

Decomposition:
- Shared package wifi_rx_pkg: SAMPLE_WIDTH, CP_LEN, N_FFT, pilot bins (7, 21, 43, 57), first data bin of the negative half (38), state encodings.
- One sub-module: wifi_rx_bin_buffer, a 64x(2*SAMPLE_WIDTH) 1W/1R RAM with registered read.
- Bin-order sequencer and both FSMs stay in the top module.

Test Plan:
- Single symbol: sym_start+last_symbol=1, then 80 valid samples with value n -> fft_in_valid for samples 16..79, fft_in_first on sample 16, input FSM back to I_IDLE.
- Feed FFT bins with re=bin index, demap_ready=1 -> 48 outputs, sym_re sequence 38,39,40,41,42,44,…,56,58,…,63,1,…,6,8,…,20,22,…,26; last_out on the 48th.
- Two back-to-back symbols, valid_in toggled 50% -> 128 fft_in samples with no gap in symbol indexing; last_out only on symbol 2.
- demap_ready low for 5 cycles at sub_idx 10 -> outputs hold, no index skipped or duplicated.
- sym_start at I_LOAD sample 30 -> fft_abort pulse, then a fresh 16-sample CP skip and a full 64-sample load.
- fft_out_valid during O_READ -> overflow=1 stays high, the 48 outputs complete correctly; reset mid-O_READ -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/wifi_rx_pkg.sv
// rtl/wifi_rx_pkg.sv - shared constants, state encodings and bin-order helper for the rx fft controller
// Purpose: sample/FFT geometry, pilot bins, FSM state codes, data-subcarrier to FFT-bin mapping.
// Ports: none (package).
package wifi_rx_pkg;

  localparam int SAMPLE_WIDTH = 12;
  localparam int CP_LEN       = 16;
  localparam int N_FFT        = 64;
  localparam int N_DATA       = 48;
  localparam int ADDR_W       = $clog2(N_FFT);
  localparam int BIN_W        = 2 * SAMPLE_WIDTH;

  localparam logic [ADDR_W-1:0] CP_LAST       = ADDR_W'(CP_LEN - 1);
  localparam logic [ADDR_W-1:0] N_LAST        = ADDR_W'(N_FFT - 1);
  localparam logic [ADDR_W-1:0] N_DATA_K      = ADDR_W'(N_DATA);
  localparam logic [ADDR_W-1:0] DATA_LAST     = ADDR_W'(N_DATA - 1);
  localparam logic [ADDR_W-1:0] HALF_DATA     = ADDR_W'(N_DATA / 2);

  // Pilot bins in natural FFT order: +7, +21, -21 (bin 43), -7 (bin 57)
  localparam logic [ADDR_W-1:0] PILOT_BIN_0   = ADDR_W'(7);
  localparam logic [ADDR_W-1:0] PILOT_BIN_1   = ADDR_W'(21);
  localparam logic [ADDR_W-1:0] PILOT_BIN_2   = ADDR_W'(43);
  localparam logic [ADDR_W-1:0] PILOT_BIN_3   = ADDR_W'(57);
  // Subcarrier -26 lands in bin 38
  localparam logic [ADDR_W-1:0] NEG_FIRST_BIN = ADDR_W'(38);

  localparam logic [1:0] I_IDLE = 2'd0;
  localparam logic [1:0] I_CP   = 2'd1;
  localparam logic [1:0] I_LOAD = 2'd2;

  localparam logic [0:0] O_WRITE = 1'b0;
  localparam logic [0:0] O_READ  = 1'b1;

  // Data subcarrier k (0..47) to FFT bin: first half walks bins 38..63,
  // second half walks 1..26, each stepping over its two pilot bins.
  function automatic logic [ADDR_W-1:0] data_bin(input logic [ADDR_W-1:0] k);
    logic [ADDR_W-1:0] b;
    if (k < HALF_DATA) begin
      b = NEG_FIRST_BIN + k;
      if (b >= PILOT_BIN_2) b = b + ADDR_W'(1);
      if (b >= PILOT_BIN_3) b = b + ADDR_W'(1);
    end else begin
      b = k - HALF_DATA + ADDR_W'(1);
      if (b >= PILOT_BIN_0) b = b + ADDR_W'(1);
      if (b >= PILOT_BIN_1) b = b + ADDR_W'(1);
    end
    return b;
  endfunction

endpackage

// File: rtl/wifi_rx_fft_controller_if.sv
// rtl/wifi_rx_fft_controller_if.sv - sample, FFT and demapper signal bundle of the rx fft controller
// Purpose: groups every non-clock/reset signal of the controller.
// Ports: rx_* / valid_in / sym_start / last_symbol (sync side), fft_in_* / fft_abort (to FFT),
//        fft_out_* (from FFT), demap_ready / sym_* / valid_out / sub_idx / last_out / overflow (demapper side).
// Modports: slave = controller view, master = surrounding environment view.
interface wifi_rx_fft_controller_if;
  import wifi_rx_pkg::*;

  logic [SAMPLE_WIDTH-1:0] rx_re;
  logic [SAMPLE_WIDTH-1:0] rx_im;
  logic                    valid_in;
  logic                    sym_start;
  logic                    last_symbol;
  logic [SAMPLE_WIDTH-1:0] fft_in_re;
  logic [SAMPLE_WIDTH-1:0] fft_in_im;
  logic                    fft_in_valid;
  logic                    fft_in_first;
  logic                    fft_abort;
  logic [SAMPLE_WIDTH-1:0] fft_out_re;
  logic [SAMPLE_WIDTH-1:0] fft_out_im;
  logic                    fft_out_valid;
  logic                    demap_ready;
  logic [SAMPLE_WIDTH-1:0] sym_re;
  logic [SAMPLE_WIDTH-1:0] sym_im;
  logic                    valid_out;
  logic [5:0]              sub_idx;
  logic                    last_out;
  logic                    overflow;

  modport slave (
    input  rx_re, rx_im, valid_in, sym_start, last_symbol,
    input  fft_out_re, fft_out_im, fft_out_valid, demap_ready,
    output fft_in_re, fft_in_im, fft_in_valid, fft_in_first, fft_abort,
    output sym_re, sym_im, valid_out, sub_idx, last_out, overflow
  );

  modport master (
    output rx_re, rx_im, valid_in, sym_start, last_symbol,
    output fft_out_re, fft_out_im, fft_out_valid, demap_ready,
    input  fft_in_re, fft_in_im, fft_in_valid, fft_in_first, fft_abort,
    input  sym_re, sym_im, valid_out, sub_idx, last_out, overflow
  );

endinterface

// File: rtl/wifi_rx_bin_buffer.sv
// rtl/wifi_rx_bin_buffer.sv - 64-entry FFT bin store, one write port, one registered read port
// Purpose: holds one symbol of FFT bins {re, im} while the data subcarriers are re-ordered out.
// Ports: clk, reset (async, active-high; clears only the read register), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr (read issued), rd_data (valid the cycle after rd_en, held otherwise).
module wifi_rx_bin_buffer
  import wifi_rx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BIN_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BIN_W-1:0]  rd_data
);

  logic [BIN_W-1:0] mem_q [N_FFT];
  logic [BIN_W-1:0] rd_data_q;
  logic [BIN_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Read data holds while rd_en is low so a stalled output beat stays stable.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/wifi_rx_fft_controller.sv
// rtl/wifi_rx_fft_controller.sv - strips cyclic prefix into the FFT and re-orders FFT bins to data subcarriers
// Purpose: input FSM (I_IDLE/I_CP/I_LOAD) forwards 64-sample symbol bodies to the FFT; output FSM
//          (O_WRITE/O_READ) buffers 64 bins and emits the 48 data subcarriers under demap_ready.
// Ports: clk, reset (async, active-high), bus (wifi_rx_fft_controller_if.slave, all data/handshake).
module wifi_rx_fft_controller
  import wifi_rx_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  wifi_rx_fft_controller_if.slave bus
);

  // ---------------- input side ----------------
  logic [1:0]        in_state_q, in_state_d;
  logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
  logic              in_last_q, in_last_d;
  logic              flag_push;
  logic              fft_sample;

  always_comb begin
    in_state_d = in_state_q;
    in_cnt_d   = in_cnt_q;
    in_last_d  = in_last_q;
    flag_push  = 1'b0;
    if (bus.valid_in) begin
      if (bus.sym_start) begin
        // Start or resync: this sample is CP sample 0, so the count resumes at 1.
        in_state_d = I_CP;
        in_cnt_d   = ADDR_W'(1);
        in_last_d  = bus.last_symbol;
      end else begin
        case (in_state_q)
          I_CP: begin
            if (in_cnt_q == CP_LAST) begin
              in_state_d = I_LOAD;
              in_cnt_d   = '0;
            end else begin
              in_cnt_d = in_cnt_q + ADDR_W'(1);
            end
          end
          I_LOAD: begin
            if (in_cnt_q == N_LAST) begin
              flag_push  = 1'b1;
              in_cnt_d   = '0;
              in_state_d = in_last_q ? I_IDLE : I_CP;
            end else begin
              in_cnt_d = in_cnt_q + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state_q <= I_IDLE;
      in_cnt_q   <= '0;
      in_last_q  <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      in_cnt_q   <= in_cnt_d;
      in_last_q  <= in_last_d;
    end
  end

  // A sym_start sample is always a CP sample, never part of the body.
  assign fft_sample       = (in_state_q == I_LOAD) && bus.valid_in && !bus.sym_start;
  assign bus.fft_in_valid = fft_sample;
  assign bus.fft_in_first = fft_sample && (in_cnt_q == '0);
  assign bus.fft_in_re    = fft_sample ? bus.rx_re : '0;
  assign bus.fft_in_im    = fft_sample ? bus.rx_im : '0;
  assign bus.fft_abort    = (in_state_q == I_LOAD) && bus.valid_in && bus.sym_start;

  // ---------------- last-flag FIFO (2 entries) ----------------
  logic       fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0] fifo_cnt_q, fifo_cnt_d;
  logic       flag_pop;
  logic       pop_ok;
  logic       fifo_head;

  assign pop_ok    = flag_pop && (fifo_cnt_q != 2'd0);
  assign fifo_head = (fifo_cnt_q != 2'd0) ? fifo0_q : 1'b0;

  always_comb begin
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    fifo_cnt_d = fifo_cnt_q;
    if (pop_ok && flag_push) begin
      if (fifo_cnt_q == 2'd1) begin
        fifo0_d = in_last_q;
      end else begin
        fifo0_d = fifo1_q;
        fifo1_d = in_last_q;
      end
    end else if (pop_ok) begin
      fifo0_d    = fifo1_q;
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end else if (flag_push) begin
      if (fifo_cnt_q == 2'd0) fifo0_d = in_last_q;
      else                    fifo1_d = in_last_q;
      if (fifo_cnt_q != 2'd2) fifo_cnt_d = fifo_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo0_q    <= 1'b0;
      fifo1_q    <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // ---------------- output side ----------------
  logic [0:0]        out_state_q, out_state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] rd_k_q, rd_k_d;
  logic              valid_out_q, valid_out_d;
  logic [5:0]        sub_idx_q, sub_idx_d;
  logic              last_out_q, last_out_d;
  logic              flag_q, flag_d;
  logic              overflow_q, overflow_d;
  logic              buf_wr_en, buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [BIN_W-1:0]  buf_rd_data;

  always_comb begin
    out_state_d = out_state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_k_d      = rd_k_q;
    valid_out_d = valid_out_q;
    sub_idx_d   = sub_idx_q;
    last_out_d  = last_out_q;
    flag_d      = flag_q;
    overflow_d  = overflow_q;
    buf_wr_en   = 1'b0;
    buf_rd_en   = 1'b0;
    buf_rd_addr = data_bin(rd_k_q);
    flag_pop    = 1'b0;
    if (out_state_q == O_WRITE) begin
      if (bus.fft_out_valid) begin
        buf_wr_en = 1'b1;
        if (wr_cnt_q == N_LAST) begin
          wr_cnt_d    = '0;
          flag_pop    = 1'b1;
          flag_d      = fifo_head;
          rd_k_d      = '0;
          out_state_d = O_READ;
        end else begin
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end
      end
    end else begin
      if (bus.fft_out_valid) overflow_d = 1'b1;
      // The output register may load when empty or when its beat is being taken.
      if (!valid_out_q || bus.demap_ready) begin
        if (rd_k_q != N_DATA_K) begin
          buf_rd_en   = 1'b1;
          valid_out_d = 1'b1;
          sub_idx_d   = rd_k_q;
          last_out_d  = flag_q && (rd_k_q == DATA_LAST);
          rd_k_d      = rd_k_q + ADDR_W'(1);
        end else begin
          // Sub-index 47 is transferring now; the symbol is done.
          valid_out_d = 1'b0;
          last_out_d  = 1'b0;
          out_state_d = O_WRITE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state_q <= O_WRITE;
      wr_cnt_q    <= '0;
      rd_k_q      <= '0;
      valid_out_q <= 1'b0;
      sub_idx_q   <= '0;
      last_out_q  <= 1'b0;
      flag_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_k_q      <= rd_k_d;
      valid_out_q <= valid_out_d;
      sub_idx_q   <= sub_idx_d;
      last_out_q  <= last_out_d;
      flag_q      <= flag_d;
      overflow_q  <= overflow_d;
    end
  end

  wifi_rx_bin_buffer u_bin_buffer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_cnt_q),
    .wr_data ({bus.fft_out_re, bus.fft_out_im}),
    .rd_en   (buf_rd_en),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  assign bus.sym_re    = buf_rd_data[BIN_W-1:SAMPLE_WIDTH];
  assign bus.sym_im    = buf_rd_data[SAMPLE_WIDTH-1:0];
  assign bus.valid_out = valid_out_q;
  assign bus.sub_idx   = sub_idx_q;
  assign bus.last_out  = last_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_wifi_rx_fft_controller.sv
// tb/tb_wifi_rx_fft_controller.sv - randomized self-checking bench for wifi_rx_fft_controller
module tb_wifi_rx_fft_controller;
  import wifi_rx_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wifi_rx_fft_controller_if bus ();

  wifi_rx_fft_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] re;
    logic [11:0] im;
    logic [5:0]  idx;
    logic        last;
  } out_t;

  out_t exp_q[$];

  logic        exp_fv = 1'b0, exp_first = 1'b0, exp_abort = 1'b0;
  logic [11:0] exp_re = '0, exp_im = '0;
  logic        mon_en = 1'b0;

  int fin_count, abort_count, stall_cnt, last_cnt;
  logic [11:0] first_val;
  logic [11:0] log_re[$];
  logic        log_last[$];

  int ready_mode = 0;
  bit held = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic clear_stats();
    fin_count = 0; abort_count = 0; stall_cnt = 0; last_cnt = 0;
    first_val = '0; log_re.delete(); log_last.delete(); held = 0;
  endtask

  // ---------------- compare process ----------------
  logic        p_stall = 1'b0;
  logic [11:0] p_re, p_im;
  logic [5:0]  p_idx;
  logic        p_last;

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk("fft_in_valid", 32'(bus.fft_in_valid), 32'(exp_fv));
      chk("fft_in_first", 32'(bus.fft_in_first), 32'(exp_first));
      chk("fft_abort", 32'(bus.fft_abort), 32'(exp_abort));
      if (exp_fv) begin
        chk("fft_in_re", 32'(bus.fft_in_re), 32'(exp_re));
        chk("fft_in_im", 32'(bus.fft_in_im), 32'(exp_im));
      end
      if (bus.fft_in_valid) fin_count++;
      if (bus.fft_in_valid && bus.fft_in_first) first_val = bus.fft_in_re;
      if (bus.fft_abort) abort_count++;

      if (p_stall) begin
        chk("hold_valid", 32'(bus.valid_out), 32'd1);
        chk("hold_re", 32'(bus.sym_re), 32'(p_re));
        chk("hold_im", 32'(bus.sym_im), 32'(p_im));
        chk("hold_idx", 32'(bus.sub_idx), 32'(p_idx));
        chk("hold_last", 32'(bus.last_out), 32'(p_last));
      end
      if (!bus.valid_out) chk("last_without_valid", 32'(bus.last_out), 32'd0);

      if (bus.valid_out && bus.demap_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got sub_idx %0d expected no output", bus.sub_idx);
        end else begin
          out_t e;
          e = exp_q.pop_front();
          chk("sym_re", 32'(bus.sym_re), 32'(e.re));
          chk("sym_im", 32'(bus.sym_im), 32'(e.im));
          chk("sub_idx", 32'(bus.sub_idx), 32'(e.idx));
          chk("last_out", 32'(bus.last_out), 32'(e.last));
        end
        log_re.push_back(bus.sym_re);
        log_last.push_back(bus.last_out);
        if (bus.last_out) last_cnt++;
      end
      if (bus.valid_out && !bus.demap_ready && bus.sub_idx == 6'd10) stall_cnt++;

      p_stall = bus.valid_out && !bus.demap_ready;
      p_re = bus.sym_re; p_im = bus.sym_im; p_idx = bus.sub_idx; p_last = bus.last_out;
    end else begin
      p_stall = 1'b0;
    end
  end

  // ---------------- demapper ready driver ----------------
  initial begin
    bus.demap_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.demap_ready = 1'b1;
        1: bus.demap_ready = ($urandom_range(99) < 60);
        default: begin
          if (!held && bus.valid_out && bus.sub_idx == 6'd10) begin
            held = 1;
            bus.demap_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 bus.demap_ready = 1'b1;
          end else begin
            bus.demap_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- sample stimulus ----------------
  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.valid_in = 1'b0; bus.sym_start = 1'b0; bus.last_symbol = 1'($urandom);
    bus.rx_re = 12'($urandom); bus.rx_im = 12'($urandom);
    exp_fv = 1'b0; exp_first = 1'b0; exp_abort = 1'b0;
  endtask

  task automatic send_sample(input logic ss, input logic ls, input logic [11:0] re, input logic [11:0] im,
                             input logic body, input logic first, input logic abort, input int pct);
    while ($urandom_range(99) >= pct) idle_cycle();
    @(posedge clk); #1;
    bus.valid_in = 1'b1; bus.sym_start = ss;
    bus.last_symbol = ss ? ls : 1'($urandom);
    bus.rx_re = re; bus.rx_im = im;
    exp_fv = body; exp_first = first; exp_abort = abort; exp_re = re; exp_im = im;
  endtask

  // One symbol as the sync block delivers it: CP, then n_body samples of the body.
  task automatic send_symbol(input logic ls, input int n_body, input int pct, input logic aborts_prev, input logic ramp);
    for (int i = 0; i < CP_LEN + n_body; i++) begin
      logic [11:0] re;
      re = ramp ? 12'(i) : 12'($urandom);
      send_sample(i == 0, ls, re, 12'($urandom), i >= CP_LEN, i == CP_LEN, (i == 0) && aborts_prev, pct);
    end
  endtask

  // ---------------- FFT bin stimulus + reference order ----------------
  task automatic feed_bins(input logic lastf, input logic idx_data, input int pct);
    logic [11:0] br[64];
    logic [11:0] bi[64];
    int n;
    for (int b = 0; b < 64; b++) begin
      br[b] = idx_data ? 12'(b) : 12'($urandom);
      bi[b] = 12'($urandom);
    end
    // Subcarriers -26..+26 without DC and pilots +-7, +-21; subcarrier s sits in bin s mod 64.
    n = 0;
    for (int s = -26; s <= 26; s++) begin
      int b;
      out_t e;
      if (s == 0 || s == 7 || s == -7 || s == 21 || s == -21) continue;
      b = (s + 64) % 64;
      e.re = br[b]; e.im = bi[b]; e.idx = 6'(n); e.last = lastf && (n == 47);
      exp_q.push_back(e);
      n++;
    end
    for (int b = 0; b < 64; b++) begin
      while ($urandom_range(99) >= pct) begin
        @(posedge clk); #1 bus.fft_out_valid = 1'b0;
      end
      @(posedge clk); #1;
      bus.fft_out_valid = 1'b1; bus.fft_out_re = br[b]; bus.fft_out_im = bi[b];
    end
    @(posedge clk); #1 bus.fft_out_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(posedge clk); cyc++;
    end
    chk({name, "_outputs_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_left(input int n);
    int cyc;
    cyc = 0;
    while (exp_q.size() > n && cyc < 2000) begin
      @(posedge clk); cyc++;
    end
    chk("wait_left_timeout", 32'(cyc >= 2000), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fft_in_valid"}, 32'(bus.fft_in_valid), 32'd0);
    chk({tag, "_fft_in_first"}, 32'(bus.fft_in_first), 32'd0);
    chk({tag, "_fft_abort"}, 32'(bus.fft_abort), 32'd0);
    chk({tag, "_fft_in_re"}, 32'(bus.fft_in_re), 32'd0);
    chk({tag, "_fft_in_im"}, 32'(bus.fft_in_im), 32'd0);
    chk({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
    chk({tag, "_sym_re"}, 32'(bus.sym_re), 32'd0);
    chk({tag, "_sym_im"}, 32'(bus.sym_im), 32'd0);
    chk({tag, "_sub_idx"}, 32'(bus.sub_idx), 32'd0);
    chk({tag, "_last_out"}, 32'(bus.last_out), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    bus.valid_in = 1'b0; bus.sym_start = 1'b0; bus.last_symbol = 1'b0;
    bus.rx_re = '0; bus.rx_im = '0;
    bus.fft_out_valid = 1'b0; bus.fft_out_re = '0; bus.fft_out_im = '0;
    repeat (2) @(posedge clk); #1;
    chk_all_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    // Single symbol, ramp data, bins carry their own index.
    clear_stats();
    ready_mode = 0;
    send_symbol(1'b1, 64, 100, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_sample(1'b0, 1'b0, 12'($urandom), 12'($urandom), 1'b0, 1'b0, 1'b0, 100);
    idle_cycle();
    chk("t1_fft_in_count", 32'(fin_count), 32'd64);
    chk("t1_first_value", 32'(first_val), 32'd16);
    feed_bins(1'b1, 1'b1, 100);
    wait_drain("t1");
    chk("t1_out_count", 32'(log_re.size()), 32'd48);
    if (log_re.size() == 48) begin
      chk("t1_out0", 32'(log_re[0]), 32'd38);
      chk("t1_out5", 32'(log_re[5]), 32'd44);
      chk("t1_out18", 32'(log_re[18]), 32'd58);
      chk("t1_out23", 32'(log_re[23]), 32'd63);
      chk("t1_out24", 32'(log_re[24]), 32'd1);
      chk("t1_out30", 32'(log_re[30]), 32'd8);
      chk("t1_out47", 32'(log_re[47]), 32'd26);
      chk("t1_last47", 32'(log_last[47]), 32'd1);
      chk("t1_last46", 32'(log_last[46]), 32'd0);
    end

    // Two back-to-back symbols, 50% valid, random demapper ready.
    clear_stats();
    ready_mode = 1;
    send_symbol(1'b0, 64, 50, 1'b0, 1'b0);
    send_symbol(1'b1, 64, 50, 1'b0, 1'b0);
    idle_cycle();
    chk("t2_fft_in_count", 32'(fin_count), 32'd128);
    feed_bins(1'b0, 1'b0, 70);
    wait_drain("t2a");
    chk("t2_last_after_sym1", 32'(last_cnt), 32'd0);
    feed_bins(1'b1, 1'b0, 70);
    wait_drain("t2b");
    chk("t2_last_total", 32'(last_cnt), 32'd1);

    // Demapper stalls five cycles at sub-index 10.
    clear_stats();
    ready_mode = 2;
    send_symbol(1'b1, 64, 100, 1'b0, 1'b0);
    idle_cycle();
    feed_bins(1'b1, 1'b0, 100);
    wait_drain("t3");
    chk("t3_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("t3_out_count", 32'(log_re.size()), 32'd48);

    // Resync at load sample 30.
    clear_stats();
    ready_mode = 0;
    send_symbol(1'b0, 30, 100, 1'b0, 1'b0);
    send_symbol(1'b1, 64, 100, 1'b1, 1'b0);
    idle_cycle();
    chk("t4_abort_count", 32'(abort_count), 32'd1);
    chk("t4_fft_in_count", 32'(fin_count), 32'd94);
    feed_bins(1'b1, 1'b0, 100);
    wait_drain("t4");
    chk("t4_last_total", 32'(last_cnt), 32'd1);

    // Bin arriving while reading out.
    clear_stats();
    send_symbol(1'b1, 64, 100, 1'b0, 1'b0);
    idle_cycle();
    feed_bins(1'b1, 1'b0, 100);
    chk("t5_overflow_before", 32'(bus.overflow), 32'd0);
    wait_left(40);
    #1;
    bus.fft_out_valid = 1'b1; bus.fft_out_re = 12'($urandom); bus.fft_out_im = 12'($urandom);
    @(posedge clk); #1 bus.fft_out_valid = 1'b0;
    chk("t5_overflow_set", 32'(bus.overflow), 32'd1);
    wait_drain("t5");
    chk("t5_overflow_sticky", 32'(bus.overflow), 32'd1);
    chk("t5_out_count", 32'(log_re.size()), 32'd48);

    // Reset in the middle of read-out.
    clear_stats();
    send_symbol(1'b1, 64, 100, 1'b0, 1'b0);
    idle_cycle();
    feed_bins(1'b1, 1'b0, 100);
    wait_left(30);
    #3;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // Recovery after reset.
    clear_stats();
    ready_mode = 1;
    send_symbol(1'b1, 64, 80, 1'b0, 1'b0);
    idle_cycle();
    chk("t6_fft_in_count", 32'(fin_count), 32'd64);
    feed_bins(1'b1, 1'b1, 100);
    wait_drain("t6");
    chk("t6_last_total", 32'(last_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
